// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the memory arbiter and the
// single-port line RAM. The arbiter connects through the slave modport; the
// caches and RAM model connect through the master modport.
interface mem_arbiter_if;
    // icache side (read only)
    logic         ic_req;
    logic [25:0]  ic_addr;
    logic         ic_ack;
    logic [127:0] ic_rdata;
    // dcache side (read/write)
    logic         dc_req;
    logic         dc_we;
    logic [25:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic         dc_ack;
    logic [127:0] dc_rdata;
    // RAM side
    logic [25:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_we;
    logic [127:0] mem_rdata;
    // status
    logic         busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        output ic_ack, ic_rdata, dc_ack, dc_rdata, mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        input  ic_ack, ic_rdata, dc_ack, dc_rdata, mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 128-bit-line RAM between the icache
// (read only) and the dcache (read/write). Each access runs IDLE -> BUSY ->
// RESP: the winner's request is latched at grant, held on the RAM for
// MEM_LATENCY cycles, the line is registered on the last BUSY cycle and a
// one-cycle ack is returned in RESP.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration on ties
// (requester not granted last wins). Without it, dcache has fixed priority.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         owner_q, owner_d;      // 1 = dcache owns the current access
    logic         we_q, we_d;
    logic [25:0]  addr_q, addr_d;
    logic [127:0] wdata_q, wdata_d;
    logic         ic_ack_q, ic_ack_d;
    logic         dc_ack_q, dc_ack_d;
    logic [127:0] ic_rdata_q, ic_rdata_d;
    logic [127:0] dc_rdata_q, dc_rdata_d;
    logic         req_any;
    logic         grant_dc;              // winner if a grant happens this cycle

    assign req_any = bus.ic_req | bus.dc_req;

`ifdef MEM_ARB_RR_EN
    logic last_dc_q, last_dc_d;          // 1 = dcache was granted last

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant_dc = bus.dc_req & (~bus.ic_req | ~last_dc_q);
    end

    // Pointer follows every grant.
    always_comb begin
        last_dc_d = last_dc_q;
        if (state_q == IDLE && req_any) begin
            last_dc_d = grant_dc;
        end
    end

    // Pointer register; resets to dcache-last so icache wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dc_q <= 1'b1;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end
`else
    // Fixed priority: dcache beats icache.
    always_comb begin
        grant_dc = bus.dc_req;
    end
`endif

    // Next-state and register-update logic for the access sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_ack_d   = 1'b0;
        dc_ack_d   = 1'b0;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    owner_d = grant_dc;
                    addr_d  = grant_dc ? bus.dc_addr : bus.ic_addr;
                    we_d    = grant_dc & bus.dc_we;
                    if (grant_dc) begin
                        wdata_d = bus.dc_wdata;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Last hold cycle: register the line for the owner and
                    // raise its ack for the RESP cycle.
                    if (owner_q) begin
                        dc_rdata_d = bus.mem_rdata;
                        dc_ack_d   = 1'b1;
                    end else begin
                        ic_rdata_d = bus.mem_rdata;
                        ic_ack_d   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_ack_q   <= 1'b0;
            dc_ack_q   <= 1'b0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_ack_q   <= ic_ack_d;
            dc_ack_q   <= dc_ack_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    // Write enable is decoded from state so a reset drops it immediately,
    // and it is only high on the final hold cycle of a write.
    assign bus.mem_we    = (state_q == BUSY) & we_q & (cnt_q == '0);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q == BUSY) | (state_q == RESP);
    assign bus.ic_ack    = ic_ack_q;
    assign bus.dc_ack    = dc_ack_q;
    assign bus.ic_rdata  = ic_rdata_q;
    assign bus.dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbiter and RAM.
// A second instance built with MEM_LATENCY=1 covers the shortest latency.
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter_if bus1();

    mem_arbiter #(.MEM_LATENCY(LAT), .CNT_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Power-up RAM content: 32-bit word k of line a holds 4*a + k.
    function automatic logic [127:0] init_line(input logic [25:0] a);
        logic [31:0] b;
        b = {4'b0000, a, 2'b00};
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // RAM stub: combinational read, write on the clock edge while mem_we.
    bit           ram_wr [256];
    logic [127:0] ram_dat[256];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram_wr[bus.mem_addr[7:0]]  <= 1'b1;
            ram_dat[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata  = ram_wr[bus.mem_addr[7:0]] ? ram_dat[bus.mem_addr[7:0]]
                                                      : init_line(bus.mem_addr);
    assign bus1.mem_rdata = init_line(bus1.mem_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model state
    int           cyc;
    int           g_cyc, ack_at, free_at;
    bit           act, own_dc, c_we, last_dc, dc_rd_known;
    logic [25:0]  c_addr;
    logic [127:0] c_wdata, c_exp, exp_ic_rd, exp_dc_rd;
    bit           mw[256];
    logic [127:0] md[256];
    int           we_cnt, ic_ack_cyc, dc_ack_cyc;
    int           gc, w_ack, seen_we, k_ack;

    task automatic model_reset();
        act         = 1'b0;
        free_at     = 0;
        g_cyc       = 0;
        ack_at      = 0;
        last_dc     = 1'b1;
        exp_ic_rd   = '0;
        exp_dc_rd   = '0;
        dc_rd_known = 1'b1;
    endtask

    // Advance one cycle, compare outputs with the model, let requesters drop on ack.
    task automatic tick();
        bit e_ica, e_dca;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_we) we_cnt++;
        chk("busy", bus.busy, act && cyc > g_cyc && cyc <= ack_at);
        chk("mem_we", bus.mem_we, act && c_we && cyc == ack_at - 1);
        if (act && cyc > g_cyc && cyc < ack_at) begin
            chk("mem_addr", bus.mem_addr, c_addr);
            if (c_we) chk("mem_wdata", bus.mem_wdata, c_wdata);
        end
        e_ica = act && cyc == ack_at && !own_dc;
        e_dca = act && cyc == ack_at && own_dc;
        chk("ic_ack", bus.ic_ack, e_ica);
        chk("dc_ack", bus.dc_ack, e_dca);
        if (e_ica) exp_ic_rd = c_exp;
        if (e_dca) begin
            if (c_we) begin
                mw[c_addr[7:0]] = 1'b1;
                md[c_addr[7:0]] = c_wdata;
                dc_rd_known     = 1'b0;
            end else begin
                exp_dc_rd   = c_exp;
                dc_rd_known = 1'b1;
            end
        end
        if (e_ica || e_dca) begin
            chk("ic_rdata", bus.ic_rdata, exp_ic_rd);
            if (dc_rd_known) chk("dc_rdata", bus.dc_rdata, exp_dc_rd);
            act = 1'b0;
        end
        if (bus.ic_ack) begin
            ic_ack_cyc = cyc;
            bus.ic_req = 1'b0;
        end
        if (bus.dc_ack) begin
            dc_ack_cyc = cyc;
            bus.dc_req = 1'b0;
        end
    endtask

    // Decide a grant from the requests presented in the current cycle.
    task automatic grant_model();
        bit w;
        if (reset && cyc >= free_at && (bus.ic_req || bus.dc_req)) begin
            if (bus.ic_req && bus.dc_req) begin
`ifdef MEM_ARB_RR_EN
                w = !last_dc;
`else
                w = 1'b1;
`endif
            end else begin
                w = bus.dc_req;
            end
            last_dc = w;
            own_dc  = w;
            act     = 1'b1;
            g_cyc   = cyc;
            ack_at  = cyc + LAT + 1;
            free_at = cyc + LAT + 2;
            c_addr  = w ? bus.dc_addr : bus.ic_addr;
            c_we    = w && bus.dc_we;
            c_wdata = bus.dc_wdata;
            c_exp   = mw[c_addr[7:0]] ? md[c_addr[7:0]] : init_line(c_addr);
        end
    endtask

    task automatic step();
        tick();
        grant_model();
    endtask

    task automatic rand_phase(input int ncyc, input int pct);
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (!bus.ic_req && int'($urandom_range(99)) < pct) begin
                bus.ic_req  = 1'b1;
                bus.ic_addr = 26'($urandom_range(31));
            end
            if (!bus.dc_req && int'($urandom_range(99)) < pct) begin
                bus.dc_req   = 1'b1;
                bus.dc_we    = 1'($urandom_range(1));
                bus.dc_addr  = 26'($urandom_range(31));
                bus.dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            grant_model();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.ic_req = 1'b0;  bus.ic_addr = '0;
        bus.dc_req = 1'b0;  bus.dc_we = 1'b0;  bus.dc_addr = '0;  bus.dc_wdata = '0;
        bus1.ic_req = 1'b0; bus1.ic_addr = '0;
        bus1.dc_req = 1'b0; bus1.dc_we = 1'b0; bus1.dc_addr = '0; bus1.dc_wdata = '0;
        cyc = 0; we_cnt = 0; ic_ack_cyc = -1; dc_ack_cyc = -1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ic_ack", bus.ic_ack, 1'b0);
        chk("rst_dc_ack", bus.dc_ack, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 26'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 128'd0);
        chk("rst_ic_rdata", bus.ic_rdata, 128'd0);
        chk("rst_dc_rdata", bus.dc_rdata, 128'd0);
        reset = 1'b1;

        // icache read of line 0x10
        tick();
        bus.ic_req = 1'b1; bus.ic_addr = 26'h10;
        grant_model(); gc = cyc;
        repeat (LAT + 2) step();
        chk("t1_lat", ic_ack_cyc - gc, LAT + 1);
        chk("t1_rdata", bus.ic_rdata, 128'h00000043_00000042_00000041_00000040);

        // dcache write then read of line 3
        we_cnt = 0;
        tick();
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 26'h3;
        bus.dc_wdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        grant_model();
        repeat (LAT + 1) step();
        w_ack = dc_ack_cyc;
        tick();
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 26'h3;
        grant_model();
        repeat (LAT + 2) step();
        chk("t2_we_cycles", we_cnt, 1);
        chk("t2_gap", dc_ack_cyc - w_ack, LAT + 2);
        chk("t2_rdata", bus.dc_rdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

        // simultaneous requests
        tick();
        bus.ic_req = 1'b1; bus.ic_addr = 26'h7;
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 26'h8;
        grant_model();
        repeat (2 * (LAT + 2)) step();
`ifdef MEM_ARB_RR_EN
        chk("t3_order", dc_ack_cyc - ic_ack_cyc, LAT + 2);
`else
        chk("t3_order", ic_ack_cyc - dc_ack_cyc, LAT + 2);
`endif

        // saturated and sparse random traffic, then drain
        rand_phase(40, 100);
        rand_phase(300, 30);
        rand_phase(2 * (LAT + 2), 0);

        // reset in the middle of a write to line 5
        tick();
        bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 26'h5;
        bus.dc_wdata = {$urandom, $urandom, $urandom, $urandom};
        grant_model();
        we_cnt = 0;
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        chk("t5_we_async", bus.mem_we, 1'b0);
        chk("t5_busy_async", bus.busy, 1'b0);
        bus.dc_req = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 26'h5;
        grant_model();
        repeat (LAT + 2) step();
        chk("t5_we_cycles", we_cnt, 0);
        chk("t5_line5", bus.dc_rdata, init_line(26'h5));

        // MEM_LATENCY=1 instance: read then write
        @(posedge clk); #1;
        bus1.ic_req = 1'b1; bus1.ic_addr = 26'h2;
        k_ack = -1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("l1_busy", bus1.busy, 1'b1);
            if (bus1.ic_ack) begin
                if (k_ack < 0) k_ack = k;
                bus1.ic_req = 1'b0;
            end
        end
        chk("l1_lat", k_ack, 2);
        chk("l1_rdata", bus1.ic_rdata, init_line(26'h2));
        @(posedge clk); #1;
        bus1.dc_req = 1'b1; bus1.dc_we = 1'b1; bus1.dc_addr = 26'h9;
        bus1.dc_wdata = 128'h1234;
        k_ack = -1; seen_we = -1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (bus1.mem_we && seen_we < 0) seen_we = k;
            if (bus1.dc_ack) begin
                if (k_ack < 0) k_ack = k;
                bus1.dc_req = 1'b0;
            end
        end
        chk("l1_we_cyc", seen_we, 1);
        chk("l1_wack", k_ack, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port 128-bit-line RAM (26-bit line address, combinational read, level write enable) between two requesters: instruction cache (read only) and data cache (read/write).
- Sits between the cache controllers and the RAM.
- Serialises accesses, holds address, write data and write enable stable for a programmable latency window, registers the returned line, and returns a one-cycle acknowledge to the winning requester.

Parameters:
- MEM_LATENCY, 4: cycles the RAM interface is held per access, excluding grant and response cycles; legal range 1..15.
- CNT_W, 4: width of the latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ic_req  in  1  icache line read request; held high until ic_ack.
- ic_addr  in  26  icache line address; stable while ic_req is high.
- ic_ack  out  1  one-cycle pulse; ic_rdata valid in the same cycle.
- ic_rdata  out  128  returned line for icache.
- dc_req  in  1  dcache request; held high until dc_ack.
- dc_we  in  1  1 = line write, 0 = line read; stable with dc_req.
- dc_addr  in  26  dcache line address.
- dc_wdata  in  128  line write data.
- dc_ack  out  1  one-cycle pulse completing a dcache access.
- dc_rdata  out  128  returned line for dcache; valid with dc_ack on reads.
- mem_addr  out  26  to RAM line address.
- mem_wdata  out  128  to RAM write data.
- mem_we  out  1  to RAM write enable.
- mem_rdata  in  128  from RAM combinational read data.
- busy  out  1  high in BUSY and RESP states.

Behaviour:
- Reset (asynchronous on the falling edge of reset, held while low):
  - state = IDLE; the following are all 0: counter, ic_ack, dc_ack, ic_rdata, dc_rdata, mem_addr, mem_wdata, mem_we, busy.
  - Owner/round-robin pointer = dcache-last, so icache wins the first tie.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If either req is high, pick the winner and latch its address, write data (dcache only), we (icache forces 0) and owner.
  - Load counter = MEM_LATENCY-1 and go to BUSY the next cycle.
  - With no request, stay in IDLE; mem_we = 0.
- Arbitration without the optional feature: fixed priority, dcache beats icache.
- BUSY:
  - mem_addr and mem_wdata are driven from the latched registers for the whole state.
  - mem_we = latched_we AND (counter == 0), so it is high for exactly one cycle per write.
  - Counter decrements each cycle.
  - At counter == 0: capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - Assert the owner's ack for exactly one cycle. The non-owner ack stays 0, and the non-owner rdata register holds its previous value.
  - Next state is IDLE.
- Latency: request seen in cycle T (IDLE) gives ack in cycle T+MEM_LATENCY+1. The minimum issue interval between grants is MEM_LATENCY+2 cycles.
- Requester rule: a requester samples ack on the edge ending RESP and drops req, or presents a new request, for the following IDLE cycle. A req still high in IDLE is treated as a new request.
- Write response: dc_rdata content on a write ack is unspecified; the bench does not check it.
- Simultaneous requests: exactly one is granted. The loser keeps its req high and is granted in the IDLE cycle after the winner's RESP.
- Request changes while BUSY or RESP are ignored, because all inputs were latched at grant.
- Reset mid-access: the access is aborted with no ack. mem_we falls immediately (asynchronously), and the RAM write is not performed unless its single mem_we cycle had already elapsed.
- MEM_LATENCY = 1: BUSY lasts one cycle with counter already 0. For a write, mem_we is high in that cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the requester not granted last wins; the pointer updates at every grant. A lone requester is always granted.
- Not defined: fixed priority, dcache over icache. The pointer register is not built.

Test Plan:
- Reset, then icache read at 0x0000010 with RAM line 0x...0043_0042_0041_0040 -> ic_ack exactly 5 cycles after the grant cycle (MEM_LATENCY=4); ic_rdata equals that line; dc_ack stays 0; busy high for 5 cycles.
- dcache write of 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D to line 0x0000003, then dcache read of the same line -> mem_we high exactly one cycle; the read returns the written value; the second ack arrives 6 cycles after the first.
- ic_req and dc_req raised in the same cycle, MEM_ARB_RR_EN undefined -> dc_ack first, ic_ack 6 cycles later; with the macro defined and the pointer at reset -> ic_ack first, dc_ack 6 cycles later.
- Both requesters held continuously for 4 accesses with MEM_ARB_RR_EN defined -> grants alternate ic, dc, ic, dc; no requester is granted twice in a row.
- reset pulled low during BUSY of a write at line 0x0000005 before the final BUSY cycle -> mem_we never asserted; no ack; line 5 unchanged; after release, state is IDLE and the next request completes normally.
- MEM_LATENCY=1 build, icache read at line 0x0000002 -> ic_ack 2 cycles after the grant cycle with the correct data.
